csi_pkt_sequencer: RTL

- Controls the CSI-2 receive packet datapath that sits downstream of lane merging.
- Takes the 16-bit merged byte stream and identifies packet headers (Data ID, word count, ECC).
- Sequences each packet through header, payload and CRC phases.
- Drives frame/line framing flags and a payload word stream to the pixel unpacker, filtered to one virtual channel.

---
 rtl/csi_pkt_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/csi_pkt_sequencer.sv
// CSI-2 receive packet sequencer: parses headers from the merged 16-bit byte stream,
// walks each packet through header/payload/CRC and forwards payload of one virtual channel.
module csi_pkt_sequencer #(
  parameter logic [1:0]  VC_ID  = 2'd0,
  parameter logic [15:0] MAX_WC = 16'd8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        dout_last,
  output logic        dout_odd,
  output logic        fr_active,
  output logic        fr_valid,
  output logic [5:0]  data_type,
  output logic        pkt_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StHdr1    = 2'd1;
  localparam logic [1:0] StPayload = 2'd2;
  localparam logic [1:0] StCrc     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic        fwd_q, fwd_d;
  logic        odd_q, odd_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dout_last_q, dout_last_d;
  logic        dout_odd_q, dout_odd_d;
  logic        fr_active_q, fr_active_d;
  logic        fr_valid_q, fr_valid_d;
  logic [5:0]  data_type_q, data_type_d;
  logic        pkt_err_q, pkt_err_d;

  logic [15:0] wc;
  logic        vc_match;

  assign wc       = {din[7:0], wc_lo_q};
  assign vc_match = (di_q[7:6] == VC_ID);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    di_d         = di_q;
    wc_lo_d      = wc_lo_q;
    fwd_d        = fwd_q;
    odd_d        = odd_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    dout_odd_d   = 1'b0;
    fr_active_d  = fr_active_q;
    fr_valid_d   = fr_valid_q;
    data_type_d  = data_type_q;
    pkt_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StIdle: begin
          di_d    = din[7:0];
          wc_lo_d = din[15:8];
          state_d = StHdr1;
        end
        StHdr1: begin
          data_type_d = di_q[5:0];
          state_d     = StIdle;
          if (di_q[5:4] == 2'b00) begin
            // Short packets of other virtual channels are dropped without error.
            if (vc_match) begin
              unique case (di_q[3:0])
                4'h0: begin
                  if (fr_active_q) pkt_err_d = 1'b1;
                  else             fr_active_d = 1'b1;
                end
                4'h1: begin
                  if (!fr_active_q) pkt_err_d = 1'b1;
                  else              fr_active_d = 1'b0;
                end
                4'h2, 4'h3: ;
                default: pkt_err_d = 1'b1;
              endcase
            end
          end else if (wc != 16'd0 && wc <= MAX_WC) begin
            state_d    = StPayload;
            cnt_d      = {1'b0, wc[15:1]} + {15'd0, wc[0]};
            odd_d      = wc[0];
            fwd_d      = vc_match && fr_active_q;
            fr_valid_d = vc_match && fr_active_q;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
        StPayload: begin
          dout_valid_d = fwd_q;
          if (fwd_q) dout_d = din;
          if (cnt_q == 16'd1) begin
            dout_last_d = fwd_q;
            dout_odd_d  = fwd_q && odd_q;
            fr_valid_d  = 1'b0;
            state_d     = StCrc;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        StCrc: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      di_q         <= 8'd0;
      wc_lo_q      <= 8'd0;
      fwd_q        <= 1'b0;
      odd_q        <= 1'b0;
      dout_q       <= 16'd0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_odd_q   <= 1'b0;
      fr_active_q  <= 1'b0;
      fr_valid_q   <= 1'b0;
      data_type_q  <= 6'd0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      di_q         <= di_d;
      wc_lo_q      <= wc_lo_d;
      fwd_q        <= fwd_d;
      odd_q        <= odd_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_odd_q   <= dout_odd_d;
      fr_active_q  <= fr_active_d;
      fr_valid_q   <= fr_valid_d;
      data_type_q  <= data_type_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_odd   = dout_odd_q;
  assign fr_active  = fr_active_q;
  assign fr_valid   = fr_valid_q;
  assign data_type  = data_type_q;
  assign pkt_err    = pkt_err_q;

endmodule
